// File: rtl/mem_access_stage.sv
// MEM-stage data memory: word/byte loads and stores with a fixed
// multi-cycle latency, upstream stall, and sticky illegal-access capture.
module mem_access_stage #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ByteOp,
  input  logic [15:0] Address,
  input  logic [15:0] StoreData,
  input  logic [31:0] ALUResultIn,
  output logic [31:0] ResultOut,
  output logic        Stall,
  output logic        Done,
  output logic        Fault,
  output logic [15:0] FaultAddr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [16:0] LIMIT = 17'(2 * DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic        op_read;
  logic        op_byte;
  logic [AW:0] op_addr;
  logic [15:0] op_data;
  logic [15:0] rdata;

  logic [15:0] mem [DEPTH];

  logic req, illegal, accept, bad, finish;
  logic c_read, c_byte;
  logic [AW:0] c_addr;
  logic [15:0] c_data;
  logic [AW-1:0] c_idx;
  logic [15:0] old_word, new_word, load_val;
  logic [7:0] rbyte;

  assign req     = MemRead | MemWrite;
  assign illegal = (MemRead & MemWrite)
                 | (~ByteOp & Address[0])
                 | ({1'b0, Address} >= LIMIT);
  assign accept  = (state == IDLE) & req & ~illegal;
  assign bad     = (state == IDLE) & req & illegal;
  assign finish  = (accept && (LATENCY == 1))
                 || ((state == BUSY) && (cnt <= 4'd1));

  // With LATENCY = 1 the commit happens on the acceptance edge,
  // so the access operands come straight from the inputs.
  assign c_read = (state == IDLE) ? MemRead : op_read;
  assign c_byte = (state == IDLE) ? ByteOp : op_byte;
  assign c_addr = (state == IDLE) ? Address[AW:0] : op_addr;
  assign c_data = (state == IDLE) ? StoreData : op_data;
  assign c_idx  = c_addr[AW:1];

  assign old_word = mem[c_idx];
  assign rbyte    = c_addr[0] ? old_word[15:8] : old_word[7:0];

  always_comb begin
    new_word = c_data;
    load_val = old_word;
    if (c_byte) begin
      load_val = {{8{rbyte[7]}}, rbyte};
      if (c_addr[0]) new_word = {c_data[7:0], old_word[7:0]};
      else           new_word = {old_word[15:8], c_data[7:0]};
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = CNT_INIT;
          state_nx = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (finish) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign Stall = rst & (accept | (state == BUSY));
  assign Done  = rst & (state == DONE);
  assign ResultOut = ((state == DONE) && op_read) ?
                     {16'h0000, rdata} : ALUResultIn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_read   <= 1'b0;
      op_byte   <= 1'b0;
      op_addr   <= '0;
      op_data   <= '0;
      rdata     <= '0;
      Fault     <= 1'b0;
      FaultAddr <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        op_read <= MemRead;
        op_byte <= ByteOp;
        op_addr <= Address[AW:0];
        op_data <= StoreData;
      end
      if (finish && c_read) rdata <= load_val;
      if (bad) begin
        Fault <= 1'b1;
        if (!Fault) FaultAddr <= Address;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (finish && !c_read) begin
      mem[c_idx] <= new_word;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stall timing, byte lanes,
// faults, pass-through and reset during an access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, ByteOp;
  logic [15:0] Address, StoreData;
  logic [31:0] ALUResultIn;
  logic [31:0] ResultOut;
  logic        Stall, Done, Fault;
  logic [15:0] FaultAddr;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.DEPTH(128), .LATENCY(2)) dut (
    .clk(clk),
    .rst(rst),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .ByteOp(ByteOp),
    .Address(Address),
    .StoreData(StoreData),
    .ALUResultIn(ALUResultIn),
    .ResultOut(ResultOut),
    .Stall(Stall),
    .Done(Done),
    .Fault(Fault),
    .FaultAddr(FaultAddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic by,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic [31:0] alu);
    MemRead     = rd;
    MemWrite    = wr;
    ByteOp      = by;
    Address     = a;
    StoreData   = d;
    ALUResultIn = alu;
  endtask

  // Entered just after a rising edge with the DUT idle.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic by, input logic [15:0] a,
                        input logic [15:0] d, input logic [31:0] alu,
                        input logic [31:0] exp);
    drive(rd, wr, by, a, d, alu);
    #1;
    chk({tag, ".stall0"}, {31'b0, Stall}, 32'd1);
    chk({tag, ".done0"}, {31'b0, Done}, 32'd0);
    @(posedge clk); #2;
    chk({tag, ".stall1"}, {31'b0, Stall}, 32'd1);
    chk({tag, ".done1"}, {31'b0, Done}, 32'd0);
    @(posedge clk); #2;
    chk({tag, ".stall2"}, {31'b0, Stall}, 32'd0);
    chk({tag, ".done2"}, {31'b0, Done}, 32'd1);
    chk({tag, ".result"}, ResultOut, exp);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, alu);
    #1;
    chk({tag, ".stall3"}, {31'b0, Stall}, 32'd0);
    chk({tag, ".done3"}, {31'b0, Done}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h1234_5678);
    #12;
    chk("rst.stall", {31'b0, Stall}, 32'd0);
    chk("rst.done", {31'b0, Done}, 32'd0);
    chk("rst.fault", {31'b0, Fault}, 32'd0);
    chk("rst.faddr", {16'b0, FaultAddr}, 32'd0);
    chk("rst.result", ResultOut, 32'h1234_5678);
    @(posedge clk); #1;
    rst = 1'b1;

    access("sw10", 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF,
           32'hAAAA_0001, 32'hAAAA_0001);
    access("lw10", 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000,
           32'hAAAA_0002, 32'h0000_BEEF);

    access("sw20", 1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234,
           32'h0, 32'h0);
    access("sb21", 1'b0, 1'b1, 1'b1, 16'h0021, 16'h0080,
           32'h0, 32'h0);
    access("lw20", 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000,
           32'h0, 32'h0000_8034);
    access("lb21", 1'b1, 1'b0, 1'b1, 16'h0021, 16'h0000,
           32'h0, 32'h0000_FF80);
    access("lb20", 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000,
           32'h0, 32'h0000_0034);

    drive(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 32'h0BAD_0003);
    #1;
    chk("flw3.stall", {31'b0, Stall}, 32'd0);
    chk("flw3.result", ResultOut, 32'h0BAD_0003);
    chk("flw3.pre", {31'b0, Fault}, 32'd0);
    @(posedge clk); #1;
    chk("flw3.fault", {31'b0, Fault}, 32'd1);
    chk("flw3.faddr", {16'b0, FaultAddr}, 32'h0000_0003);

    drive(1'b0, 1'b1, 1'b0, 16'h1000, 16'hDEAD, 32'h0BAD_1000);
    #1;
    chk("fsw.stall", {31'b0, Stall}, 32'd0);
    @(posedge clk); #1;
    chk("fsw.fault", {31'b0, Fault}, 32'd1);
    chk("fsw.faddr", {16'b0, FaultAddr}, 32'h0000_0003);

    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1111, 32'h0BAD_0010);
    #1;
    chk("frw.stall", {31'b0, Stall}, 32'd0);
    @(posedge clk); #1;
    chk("frw.faddr", {16'b0, FaultAddr}, 32'h0000_0003);

    drive(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 32'h0BAD_0100);
    #1;
    chk("flb100.stall", {31'b0, Stall}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0);

    access("lw02", 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000,
           32'h0, 32'h0000_0000);
    access("lw00", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000,
           32'h0, 32'h0000_0000);
    access("lw10b", 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000,
           32'h0, 32'h0000_BEEF);

    access("sbff", 1'b0, 1'b1, 1'b1, 16'h00FF, 16'h007F,
           32'h0, 32'h0);
    access("lbff", 1'b1, 1'b0, 1'b1, 16'h00FF, 16'h0000,
           32'h0, 32'h0000_007F);
    access("lwfe", 1'b1, 1'b0, 1'b0, 16'h00FE, 16'h0000,
           32'h0, 32'h0000_7F00);

    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0001_0002);
    #1;
    chk("pass.result", ResultOut, 32'h0001_0002);
    chk("pass.stall", {31'b0, Stall}, 32'd0);
    @(posedge clk); #1;

    drive(1'b0, 1'b1, 1'b0, 16'h0004, 16'h5555, 32'h0000_0777);
    #1;
    chk("rmid.stall0", {31'b0, Stall}, 32'd1);
    @(posedge clk); #2;
    chk("rmid.stall1", {31'b0, Stall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rmid.stall", {31'b0, Stall}, 32'd0);
    chk("rmid.done", {31'b0, Done}, 32'd0);
    chk("rmid.result", ResultOut, 32'h0000_0777);
    chk("rmid.fault", {31'b0, Fault}, 32'd0);
    chk("rmid.faddr", {16'b0, FaultAddr}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0);
    @(posedge clk); #2;
    chk("rmid.nodone", {31'b0, Done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    access("lw04", 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000,
           32'h0, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage data-memory unit of the 5-stage pipelined datapath. It sits between the EXMEM and MEMWB pipeline registers and owns the data memory. It performs word and byte loads and stores at a byte address produced by the main ALU. It models a multi-cycle memory: it stalls the upstream stages until each access completes, and passes non-memory results through unchanged to MEMWB.

Parameters:
DEPTH, 128, number of 16-bit words in data memory; byte address range is 0 to 2*DEPTH-1.
LATENCY, 2, cycles from request acceptance to completion; legal range 1-15.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
MemRead  input  1  load request, from the EXMEM control field.
MemWrite  input  1  store request, from the EXMEM control field.
ByteOp  input  1  1 = byte access, 0 = 16-bit word access.
Address  input  16  byte address, taken from ALUResultOut[15:0] of EXMEM.
StoreData  input  16  store operand, from OP1Out of EXMEM.
ALUResultIn  input  32  EX result, passed through for non-load instructions.
ResultOut  output  32  value presented to MEMWB DataIn.
Stall  output  1  hold PC, IFID, IDEX and EXMEM this cycle.
Done  output  1  one-cycle pulse; a memory access completed this cycle.
Fault  output  1  sticky flag for an illegal access.
FaultAddr  output  16  address of the first faulting access.

Behaviour:
- Reset (asynchronous, active-low):
  - clock and reset: one clock; reset is asynchronous and active-low.
  - state = IDLE, counter = 0.
  - All memory words = 16'h0000.
  - Stall = 0, Done = 0, Fault = 0, FaultAddr = 0.
  - ResultOut = ALUResultIn, because it is combinational in IDLE.
- Request: req = MemRead | MemWrite.
- Illegal request; any one of these:
  - MemRead & MemWrite both 1.
  - Word access with Address[0] = 1.
  - Address >= 2*DEPTH.
  - Response to an illegal request:
    - No memory access, Stall = 0, and ResultOut = ALUResultIn.
    - Fault is set at the next edge.
    - FaultAddr captures Address only if Fault was 0; later faults leave it unchanged.
- States:
  - IDLE:
    - Legal req: Stall = 1 combinationally. At the edge, latch op, address and data, load counter = LATENCY-1, then go to BUSY, or to DONE when LATENCY = 1.
    - No req: Stall = 0 and ResultOut = ALUResultIn.
  - BUSY:
    - Stall = 1 and the counter decrements each edge.
    - The request inputs are ignored (EXMEM is held).
    - On the edge where the counter reaches 0:
      - A store commits to memory.
      - A load's data is registered into the read-data register.
      - State goes to DONE.
  - DONE:
    - Stall = 0 and Done = 1.
    - ResultOut = {16'h0000, read-data} for loads, ALUResultIn for stores.
    - The next edge always returns to IDLE. The still-visible request is not re-accepted, because the pipeline advances on that edge.
- Timing: a request first seen in cycle T0 gives Stall = 1 in cycles T0 to T0+LATENCY-1, and Done with valid data in cycle T0+LATENCY.
- Byte lanes (little-endian):
  - Address[0] = 0 selects bits [7:0]; Address[0] = 1 selects bits [15:8].
  - A byte store writes only the selected lane; the other lane is preserved.
  - A byte load sign-extends the selected byte to 16 bits.
  - The word index is Address[15:1].
- Reset mid-access:
  - State returns to IDLE immediately and any pending store is discarded.
  - All outputs take their reset values.
- Widths: the upper 16 bits of ResultOut are 0 for every load, including byte loads.

Test Plan:
1. Reset values: hold rst = 0 with ALUResultIn = 32'h1234_5678 -> Stall = 0, Done = 0, Fault = 0, FaultAddr = 0, ResultOut = 32'h1234_5678.
2. Word store then load, LATENCY = 2:
   - SW with Address = 16'h0010, StoreData = 16'hBEEF -> Stall high for exactly 2 cycles, then a 1-cycle Done.
   - LW from 16'h0010 -> same stall pattern, and ResultOut = 32'h0000_BEEF in the Done cycle.
3. Byte lanes:
   - SB 8'h80 to 16'h0021, then LW from 16'h0020 -> 16'h80xx, with the lower byte unchanged.
   - LB from 16'h0021 -> 32'h0000_FF80.
4. Faults:
   - LW from 16'h0003 -> no stall, Fault = 1, FaultAddr = 16'h0003, memory unchanged.
   - A later SW to 16'h1000 (out of range for DEPTH = 128) -> FaultAddr stays 16'h0003.
5. Pass-through: MemRead = MemWrite = 0, ALUResultIn = 32'h0001_0002 -> ResultOut = 32'h0001_0002 the same cycle, Stall = 0.
6. Reset mid-access: SW of 16'h5555 to 16'h0004, with rst pulsed low during BUSY -> state IDLE and Stall = 0 immediately; a subsequent LW from 16'h0004 returns 32'h0000_0000.
